ddbb128_cfg_bridge: RTL and testbench

- Upstream master-side stage that turns CPU bus accesses into a memory-mapped configuration window, then into single configuration cycles on the 128-bit device config bus.
- Drives cs_config/we/sel/adr/dat into the device config-space blocks and returns their read data to the CPU with an ack.
- Runs one access at a time.
- Detects non-responding targets by timeout (master abort): reads then return all-ones and a sticky error flag is set.

---
 rtl/ddbb128_cfg_bridge_if.sv | 47 ++++
 rtl/ddbb128_cfg_bridge.sv | 146 ++++++++++++++
 tb/tb_ddbb128_cfg_bridge.sv | 474 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddbb128_cfg_bridge_if.sv
// Bus bundle between a CPU-side master and the configuration bridge.
// Holds both the CPU access signals (cyc/stb/we/sel/adr/dat, ack/dat_o)
// and the device config-bus signals (cs_config/cfg_*), plus the
// master-abort status pair (abort_o, err_o, clr_err_i).
//   slave  : view used by ddbb128_cfg_bridge
//   master : view used by whatever drives the CPU side and models targets
interface ddbb128_cfg_bridge_if;
    // CPU side
    logic         cyc_i;
    logic         stb_i;
    logic         we_i;
    logic [15:0]  sel_i;
    logic [31:0]  adr_i;
    logic [127:0] dat_i;
    logic         ack_o;
    logic [127:0] dat_o;
    // Device config bus
    logic         cs_config_o;
    logic         cfg_we_o;
    logic [15:0]  cfg_sel_o;
    logic [31:0]  cfg_adr_o;
    logic [127:0] cfg_dat_o;
    logic [127:0] cfg_dat_i;
    logic         cfg_ack_i;
    // Master-abort status
    logic         abort_o;
    logic         err_o;
    logic         clr_err_i;

    modport slave (
        input  cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        output ack_o, dat_o,
        output cs_config_o, cfg_we_o, cfg_sel_o, cfg_adr_o, cfg_dat_o,
        input  cfg_dat_i, cfg_ack_i,
        output abort_o, err_o,
        input  clr_err_i
    );

    modport master (
        output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        input  ack_o, dat_o,
        input  cs_config_o, cfg_we_o, cfg_sel_o, cfg_adr_o, cfg_dat_o,
        output cfg_dat_i, cfg_ack_i,
        input  abort_o, err_o,
        output clr_err_i
    );
endinterface

// File: rtl/ddbb128_cfg_bridge.sv
// ddbb128_cfg_bridge
// Turns CPU accesses that fall inside a memory-mapped configuration window
// into single configuration cycles on the 128-bit device config bus, one
// access at a time, and returns the read data to the CPU with a one-cycle
// ack. Non-responding targets are detected by timeout (master abort) when
// ACK_MODE = 1: reads then return all-ones and a sticky error flag is set.
//
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   bus    : ddbb128_cfg_bridge_if.slave
//            CPU side    cyc_i/stb_i/we_i/sel_i/adr_i/dat_i -> ack_o/dat_o
//            config side cs_config_o/cfg_we_o/cfg_sel_o/cfg_adr_o/cfg_dat_o,
//                        cfg_dat_i/cfg_ack_i
//            status      abort_o (pulse), err_o (sticky), clr_err_i
module ddbb128_cfg_bridge #(
    parameter logic [31:0] CFG_WIN_BASE = 32'hD000_0000,
    parameter logic [31:0] CFG_WIN_MASK = 32'hF000_0000,
    parameter logic        ACK_MODE     = 1'b0,
    parameter logic [3:0]  FIXED_LAT    = 4'd2,
    parameter logic [7:0]  TIMEOUT      = 8'd64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    ddbb128_cfg_bridge_if.slave   bus
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]   state_reg;
    logic [7:0]   count_reg;
    logic         we_reg;
    logic [15:0]  sel_reg;
    logic [31:0]  adr_reg;
    logic [127:0] wdat_reg;
    logic [127:0] cap_reg;
    logic         ack_reg;
    logic [127:0] rdat_reg;
    logic         abort_reg;
    logic         err_reg;

    logic hit;
    logic lat_reached;
    logic abort_now;

    assign hit = bus.cyc_i && bus.stb_i &&
                 ((bus.adr_i & CFG_WIN_MASK) == (CFG_WIN_BASE & CFG_WIN_MASK));

    assign lat_reached = (count_reg == {4'h0, FIXED_LAT});

    // A target ack on the timeout cycle takes precedence over the abort.
    assign abort_now = ACK_MODE && (state_reg == ST_WAIT) &&
                       !bus.cfg_ack_i && (count_reg == TIMEOUT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            count_reg <= 8'd0;
            we_reg    <= 1'b0;
            sel_reg   <= '0;
            adr_reg   <= '0;
            wdat_reg  <= '0;
            cap_reg   <= '0;
            ack_reg   <= 1'b0;
            rdat_reg  <= '0;
            abort_reg <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            // Pulse outputs default low; only DONE / abort raise them.
            ack_reg   <= 1'b0;
            rdat_reg  <= '0;
            abort_reg <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (hit) begin
                        we_reg    <= bus.we_i;
                        sel_reg   <= bus.sel_i;
                        wdat_reg  <= bus.dat_i;
                        // Config address is quad-word aligned; the low nibble
                        // is never passed through.
                        adr_reg   <= {4'h0, bus.adr_i[27:4], 4'h0};
                        state_reg <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    count_reg <= 8'd1;
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!ACK_MODE) begin
                        // Fixed-latency targets: writes finish the same way,
                        // the captured data is simply never returned.
                        if (lat_reached) begin
                            cap_reg   <= bus.cfg_dat_i;
                            state_reg <= ST_DONE;
                        end else begin
                            count_reg <= count_reg + 8'd1;
                        end
                    end else if (bus.cfg_ack_i) begin
                        cap_reg   <= bus.cfg_dat_i;
                        state_reg <= ST_DONE;
                    end else if (abort_now) begin
                        cap_reg   <= '1;
                        abort_reg <= 1'b1;
                        state_reg <= ST_DONE;
                    end else begin
                        count_reg <= count_reg + 8'd1;
                    end
                end
                ST_DONE: begin
                    // The access always completes internally; the CPU only
                    // sees an ack if it is still holding its cycle.
                    ack_reg   <= bus.cyc_i;
                    rdat_reg  <= we_reg ? '0 : cap_reg;
                    count_reg <= 8'd0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase

            // Abort sets the flag even if a clear arrives in the same cycle.
            if (abort_now) begin
                err_reg <= 1'b1;
            end else if (bus.clr_err_i) begin
                err_reg <= 1'b0;
            end
        end
    end

    assign bus.cs_config_o = (state_reg == ST_ISSUE);
    assign bus.cfg_we_o    = we_reg;
    assign bus.cfg_sel_o   = sel_reg;
    assign bus.cfg_adr_o   = adr_reg;
    assign bus.cfg_dat_o   = wdat_reg;
    assign bus.ack_o       = ack_reg;
    assign bus.dat_o       = rdat_reg;
    assign bus.abort_o     = abort_reg;
    assign bus.err_o       = err_reg;

endmodule

// File: tb/tb_ddbb128_cfg_bridge.sv
// Testbench for ddbb128_cfg_bridge. Two instances: dut0 in fixed-latency
// mode (FIXED_LAT=2) and dut1 in ack mode (TIMEOUT=8). dsel routes the CPU
// cycle to one of them and selects whose outputs the monitor observes.
// Target read data is a known function of the cycle number, so the expected
// value of any sample follows from the cycle at which it must be taken.
module tb_ddbb128_cfg_bridge;
    localparam int FLAT = 2;
    localparam int TMO  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cnt = 0;
    always @(posedge clk) cnt <= cnt + 1;

    logic         dsel = 1'b0;
    logic         cyc = 1'b0, stb = 1'b0, we = 1'b0, clr_err = 1'b0;
    logic [15:0]  sel = '0;
    logic [31:0]  adr = '0;
    logic [127:0] wdat = '0;
    int           ack_at = -1;

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [127:0] pat(input int c);
        logic [31:0] x;
        x = c;
        return {x * 32'h9E37_79B9, ~x, x ^ 32'hA5A5_5A5A, x * 32'h0100_0193 + 32'd7};
    endfunction

    logic [127:0] tgt_dat;
    logic         tgt_ack;
    assign tgt_dat = pat(cnt);
    assign tgt_ack = (cnt == ack_at);

    ddbb128_cfg_bridge_if bus0 ();
    ddbb128_cfg_bridge_if bus1 ();

    assign bus0.cyc_i     = cyc & ~dsel;
    assign bus0.stb_i     = stb;
    assign bus0.we_i      = we;
    assign bus0.sel_i     = sel;
    assign bus0.adr_i     = adr;
    assign bus0.dat_i     = wdat;
    assign bus0.cfg_dat_i = tgt_dat;
    assign bus0.cfg_ack_i = 1'b0;
    assign bus0.clr_err_i = clr_err & ~dsel;

    assign bus1.cyc_i     = cyc & dsel;
    assign bus1.stb_i     = stb;
    assign bus1.we_i      = we;
    assign bus1.sel_i     = sel;
    assign bus1.adr_i     = adr;
    assign bus1.dat_i     = wdat;
    assign bus1.cfg_dat_i = tgt_dat;
    assign bus1.cfg_ack_i = tgt_ack;
    assign bus1.clr_err_i = clr_err & dsel;

    ddbb128_cfg_bridge #(.ACK_MODE(1'b0), .FIXED_LAT(4'(FLAT))) dut0 (
        .clk_i(clk), .rst_i(rst), .bus(bus0));
    ddbb128_cfg_bridge #(.ACK_MODE(1'b1), .TIMEOUT(8'(TMO))) dut1 (
        .clk_i(clk), .rst_i(rst), .bus(bus1));

    // Observed view of the selected DUT
    logic         m_ack, m_cs, m_we, m_abort, m_err;
    logic [127:0] m_dat, m_cdat;
    logic [15:0]  m_sel;
    logic [31:0]  m_adr;
    assign m_ack   = dsel ? bus1.ack_o       : bus0.ack_o;
    assign m_cs    = dsel ? bus1.cs_config_o : bus0.cs_config_o;
    assign m_we    = dsel ? bus1.cfg_we_o    : bus0.cfg_we_o;
    assign m_abort = dsel ? bus1.abort_o     : bus0.abort_o;
    assign m_err   = dsel ? bus1.err_o       : bus0.err_o;
    assign m_dat   = dsel ? bus1.dat_o       : bus0.dat_o;
    assign m_cdat  = dsel ? bus1.cfg_dat_o   : bus0.cfg_dat_o;
    assign m_sel   = dsel ? bus1.cfg_sel_o   : bus0.cfg_sel_o;
    assign m_adr   = dsel ? bus1.cfg_adr_o   : bus0.cfg_adr_o;

    // Event log, written only here; tasks read it relative to saved sizes.
    int           cs_q[$];
    int           ack_q[$];
    logic [127:0] ackdat_q[$];
    int           abort_n = 0;
    logic [31:0]  s_adr;
    logic         s_we;
    logic [15:0]  s_sel;
    logic [127:0] s_dat;

    always @(negedge clk) begin
        if (m_cs) begin
            cs_q.push_back(cnt);
            s_adr = m_adr; s_we = m_we; s_sel = m_sel; s_dat = m_cdat;
        end
        if (m_ack) begin
            ack_q.push_back(cnt);
            ackdat_q.push_back(m_dat);
        end
        if (m_abort) abort_n = abort_n + 1;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Expected outcome of one access from the functional rules.
    function automatic void model(input bit m1, input logic w, input int j, input int h,
                                  output int ack_cyc, output logic [127:0] rd, output bit ab);
        if (!m1) begin
            ack_cyc = h + FLAT + 3;
            rd      = w ? '0 : pat(h + 1 + FLAT);
            ab      = 1'b0;
        end else if (j >= 1 && j <= TMO) begin
            ack_cyc = h + j + 3;
            rd      = w ? '0 : pat(h + 1 + j);
            ab      = 1'b0;
        end else begin
            ack_cyc = h + TMO + 3;
            rd      = w ? '0 : '1;
            ab      = 1'b1;
        end
    endfunction

    // One CPU access: strobe for a single cycle, hold cyc until ack.
    // j > 0 makes the target ack j cycles after cs_config (ack-mode DUT).
    task automatic run_access(input logic w, input logic [15:0] s, input logic [31:0] a,
                              input logic [127:0] d, input int j,
                              output int h, output int cs_b, output int ack_b, output int ab_b);
        cs_b = cs_q.size(); ack_b = ack_q.size(); ab_b = abort_n;
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
        h = cnt;
        ack_at = (j > 0) ? h + 1 + j : -1;
        tick();
        stb = 1'b0;
        for (int i = 0; i < 300 && ack_q.size() == ack_b; i++) tick();
        vectors++;
        if (ack_q.size() == ack_b) begin
            miscompares++;
            $display("FAIL ack_wait: no ack_o within 300 cycles of hit at cycle %0d", h);
        end
        cyc = 1'b0; ack_at = -1;
        tick(); tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({bus0.ack_o, bus0.cs_config_o, bus0.cfg_we_o, bus0.abort_o, bus0.err_o} !== 5'b0) begin
            miscompares++; $display("FAIL reset_ctl0: got %b want 00000",
                {bus0.ack_o, bus0.cs_config_o, bus0.cfg_we_o, bus0.abort_o, bus0.err_o});
        end
        vectors++;
        if ({bus1.ack_o, bus1.cs_config_o, bus1.cfg_we_o, bus1.abort_o, bus1.err_o} !== 5'b0) begin
            miscompares++; $display("FAIL reset_ctl1: got %b want 00000",
                {bus1.ack_o, bus1.cs_config_o, bus1.cfg_we_o, bus1.abort_o, bus1.err_o});
        end
        vectors++;
        if ({bus0.dat_o, bus0.cfg_dat_o, bus0.cfg_adr_o, bus0.cfg_sel_o} !== '0) begin
            miscompares++; $display("FAIL reset_data0: got adr=%h sel=%h nonzero data fields",
                bus0.cfg_adr_o, bus0.cfg_sel_o);
        end
        vectors++;
        if ({bus1.dat_o, bus1.cfg_dat_o, bus1.cfg_adr_o, bus1.cfg_sel_o} !== '0) begin
            miscompares++; $display("FAIL reset_data1: got adr=%h sel=%h nonzero data fields",
                bus1.cfg_adr_o, bus1.cfg_sel_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_mode0_read();
        int h, csb, ackb, abb;
        dsel = 1'b0; tick();
        run_access(1'b0, 16'hFFFF, 32'hD000_8010, '0, 0, h, csb, ackb, abb);
        vectors++;
        if (cs_q.size() - csb !== 1) begin
            miscompares++; $display("FAIL m0rd_cs_count: got %0d want 1", cs_q.size() - csb);
        end else begin
            vectors++;
            if (cs_q[csb] !== h + 1) begin
                miscompares++; $display("FAIL m0rd_cs_cycle: got %0d want %0d", cs_q[csb], h + 1);
            end
        end
        vectors++;
        if (s_adr !== 32'h0000_8010) begin
            miscompares++; $display("FAIL m0rd_cfg_adr: got %h want 00008010", s_adr);
        end
        if (ack_q.size() - ackb == 1) begin
            vectors++;
            if (ack_q[ackb] !== h + 5) begin
                miscompares++; $display("FAIL m0rd_latency: got %0d want 5", ack_q[ackb] - h);
            end
            vectors++;
            if (ackdat_q[ackb] !== pat(h + 3)) begin
                miscompares++; $display("FAIL m0rd_data: got %h want %h", ackdat_q[ackb], pat(h + 3));
            end
        end
        $display("txn m0 read adr=d0008010 hit@%0d", h);
    endtask

    task automatic test_mode0_write();
        int h, csb, ackb, abb;
        logic [127:0] d;
        d = {$urandom(), $urandom(), $urandom(), 32'hFFFF_FFFF};
        dsel = 1'b0;
        run_access(1'b1, 16'h000F, 32'hD012_3450, d, 0, h, csb, ackb, abb);
        vectors++;
        if ({s_we, s_sel} !== {1'b1, 16'h000F}) begin
            miscompares++; $display("FAIL m0wr_we_sel: got we=%b sel=%h want 1/000f", s_we, s_sel);
        end
        vectors++;
        if (s_dat !== d) begin
            miscompares++; $display("FAIL m0wr_cfg_dat: got %h want %h", s_dat, d);
        end
        vectors++;
        if (ack_q.size() - ackb !== 1) begin
            miscompares++; $display("FAIL m0wr_ack_count: got %0d want 1", ack_q.size() - ackb);
        end else begin
            vectors++;
            if (ackdat_q[ackb] !== '0) begin
                miscompares++; $display("FAIL m0wr_dat_o: got %h want 0", ackdat_q[ackb]);
            end
        end
        vectors++;
        if (m_err !== 1'b0) begin
            miscompares++; $display("FAIL m0wr_err: got %b want 0", m_err);
        end
        $display("txn m0 write adr=d0123450 sel=000f hit@%0d", h);
    endtask

    task automatic test_mode1_timeout();
        int h, csb, ackb, abb;
        dsel = 1'b1; tick();
        run_access(1'b0, 16'hFFFF, 32'hD000_0100, '0, 0, h, csb, ackb, abb);
        vectors++;
        if (abort_n - abb !== 1) begin
            miscompares++; $display("FAIL m1to_abort_count: got %0d want 1", abort_n - abb);
        end
        if (ack_q.size() > ackb) begin
            vectors++;
            if (ackdat_q[ackb] !== '1) begin
                miscompares++; $display("FAIL m1to_data: got %h want all-ones", ackdat_q[ackb]);
            end
            vectors++;
            if (ack_q[ackb] - h !== TMO + 3) begin
                miscompares++; $display("FAIL m1to_latency: got %0d want %0d", ack_q[ackb] - h, TMO + 3);
            end
        end
        vectors++;
        if (m_err !== 1'b1) begin
            miscompares++; $display("FAIL m1to_err_set: got %b want 1", m_err);
        end
        $display("txn m1 read timeout hit@%0d", h);

        // Target ack on the exact timeout cycle: data returned, no abort.
        run_access(1'b0, 16'hFFFF, 32'hD000_0200, '0, TMO, h, csb, ackb, abb);
        vectors++;
        if (abort_n - abb !== 0) begin
            miscompares++; $display("FAIL m1edge_abort: got %0d pulses want 0", abort_n - abb);
        end
        if (ack_q.size() > ackb) begin
            vectors++;
            if (ackdat_q[ackb] !== pat(h + 1 + TMO)) begin
                miscompares++; $display("FAIL m1edge_data: got %h want %h", ackdat_q[ackb], pat(h + 1 + TMO));
            end
        end
        vectors++;
        if (m_err !== 1'b1) begin
            miscompares++; $display("FAIL m1edge_err_kept: got %b want 1", m_err);
        end
        $display("txn m1 read ack-on-timeout hit@%0d", h);

        clr_err = 1'b1; tick(); clr_err = 1'b0;
        vectors++;
        if (m_err !== 1'b0) begin
            miscompares++; $display("FAIL m1_clr_err: got %b want 0", m_err);
        end
    endtask

    task automatic test_err_priority();
        int h, ackb;
        dsel = 1'b1; tick();
        ackb = ack_q.size();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'hD000_0300; h = cnt; ack_at = -1;
        tick(); stb = 1'b0;
        for (int i = 0; i < 50 && cnt < h + 1 + TMO; i++) tick();
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        vectors++;
        if ({m_abort, m_err} !== 2'b11) begin
            miscompares++; $display("FAIL err_set_wins: got abort/err=%b want 11", {m_abort, m_err});
        end
        for (int i = 0; i < 20 && ack_q.size() == ackb; i++) tick();
        cyc = 1'b0; tick();
        clr_err = 1'b1; tick(); clr_err = 1'b0; tick();
        $display("txn m1 abort with clr_err same cycle hit@%0d", h);
    endtask

    task automatic test_non_window();
        int csb, ackb;
        logic [31:0] addrs[3];
        addrs[0] = 32'h4000_0000; addrs[1] = 32'hCFFF_FFF0; addrs[2] = 32'hE000_0000;
        dsel = 1'b0; tick();
        foreach (addrs[k]) begin
            csb = cs_q.size(); ackb = ack_q.size();
            cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = addrs[k];
            repeat (20) tick();
            cyc = 1'b0; stb = 1'b0; tick(); tick();
            vectors++;
            if ((cs_q.size() - csb) + (ack_q.size() - ackb) !== 0) begin
                miscompares++; $display("FAIL non_window: adr=%h got cs=%0d ack=%0d want 0/0",
                    addrs[k], cs_q.size() - csb, ack_q.size() - ackb);
            end
            $display("txn m0 non-window adr=%h", addrs[k]);
        end
    endtask

    task automatic test_back_to_back();
        int csb, ackb;
        dsel = 1'b0; tick();
        csb = cs_q.size(); ackb = ack_q.size();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 16'hFFFF; adr = 32'hD000_1230;
        for (int i = 0; i < 100 && ack_q.size() - ackb < 2; i++) tick();
        cyc = 1'b0; stb = 1'b0;
        repeat (3) tick();
        vectors++;
        if ((ack_q.size() - ackb !== 2) || (cs_q.size() - csb !== 2)) begin
            miscompares++; $display("FAIL b2b_counts: got ack=%0d cs=%0d want 2/2",
                ack_q.size() - ackb, cs_q.size() - csb);
        end else begin
            vectors++;
            if (!(cs_q[csb] < ack_q[ackb] && cs_q[csb + 1] > ack_q[ackb])) begin
                miscompares++; $display("FAIL b2b_order: got cs1=%0d ack1=%0d cs2=%0d",
                    cs_q[csb], ack_q[ackb], cs_q[csb + 1]);
            end
            vectors++;
            if (ackdat_q[ackb + 1] !== pat(cs_q[csb + 1] + FLAT)) begin
                miscompares++; $display("FAIL b2b_data2: got %h want %h",
                    ackdat_q[ackb + 1], pat(cs_q[csb + 1] + FLAT));
            end
        end
        $display("txn m0 back-to-back reads adr=d0001230");
    endtask

    task automatic test_cpu_drop();
        int h, csb, ackb, abb;
        dsel = 1'b0; tick();
        csb = cs_q.size(); ackb = ack_q.size();
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'hD000_0400;
        tick(); cyc = 1'b0; stb = 1'b0;
        repeat (10) tick();
        vectors++;
        if ((cs_q.size() - csb !== 1) || (ack_q.size() - ackb !== 0)) begin
            miscompares++; $display("FAIL cpu_drop: got cs=%0d ack=%0d want 1/0",
                cs_q.size() - csb, ack_q.size() - ackb);
        end
        run_access(1'b0, 16'hFFFF, 32'hD000_0500, '0, 0, h, csb, ackb, abb);
        if (ack_q.size() > ackb) begin
            vectors++;
            if (ackdat_q[ackb] !== pat(h + 1 + FLAT)) begin
                miscompares++; $display("FAIL cpu_drop_next: got %h want %h", ackdat_q[ackb], pat(h + 1 + FLAT));
            end
        end
        $display("txn m0 cpu drop then read hit@%0d", h);
    endtask

    task automatic test_reset_mid();
        int h, csb, ackb, abb, i0;
        dsel = 1'b1; tick();
        ackb = ack_q.size(); abb = abort_n;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'hD000_0600; ack_at = -1; i0 = cnt;
        tick(); stb = 1'b0;
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        vectors++;
        if ({m_cs, m_ack, m_abort, m_we} !== 4'b0 || m_adr !== 32'h0) begin
            miscompares++; $display("FAIL reset_mid_outputs: got cs/ack/abort/we=%b adr=%h want 0",
                {m_cs, m_ack, m_abort, m_we}, m_adr);
        end
        repeat (14) tick();
        cyc = 1'b0; tick();
        vectors++;
        if ((ack_q.size() - ackb) + (abort_n - abb) !== 0) begin
            miscompares++; $display("FAIL reset_mid_quiet: got ack=%0d abort=%0d want 0/0",
                ack_q.size() - ackb, abort_n - abb);
        end
        $display("txn m1 reset during wait hit@%0d", i0);
        run_access(1'b0, 16'hFFFF, 32'hD000_0700, '0, 3, h, csb, ackb, abb);
        if (ack_q.size() > ackb) begin
            vectors++;
            if (ack_q[ackb] !== h + 6 || ackdat_q[ackb] !== pat(h + 4)) begin
                miscompares++; $display("FAIL reset_mid_fresh: got ack@+%0d dat=%h want +6 %h",
                    ack_q[ackb] - h, ackdat_q[ackb], pat(h + 4));
            end
        end
        $display("txn m1 fresh read after reset hit@%0d", h);
    endtask

    task automatic test_random(input bit m1, input int n);
        int h, csb, ackb, abb, j, exp_ack;
        logic [127:0] exp_rd, d;
        bit exp_ab;
        logic w;
        logic [15:0] s;
        logic [31:0] a;
        dsel = m1; tick();
        for (int t = 0; t < n; t++) begin
            w = 1'($urandom_range(0, 1));
            s = 16'($urandom());
            a = {4'hD, 28'($urandom())};
            d = {$urandom(), $urandom(), $urandom(), $urandom()};
            j = m1 ? int'($urandom_range(1, TMO + 2)) : 0;
            run_access(w, s, a, d, j, h, csb, ackb, abb);
            model(m1, w, j, h, exp_ack, exp_rd, exp_ab);
            vectors++;
            if (ack_q.size() - ackb !== 1) begin
                miscompares++; $display("FAIL rnd_ack_count: got %0d want 1", ack_q.size() - ackb);
            end else begin
                vectors++;
                if (ack_q[ackb] !== exp_ack) begin
                    miscompares++; $display("FAIL rnd_latency: got %0d want %0d", ack_q[ackb] - h, exp_ack - h);
                end
                vectors++;
                if (ackdat_q[ackb] !== exp_rd) begin
                    miscompares++; $display("FAIL rnd_data: got %h want %h", ackdat_q[ackb], exp_rd);
                end
            end
            vectors++;
            if (cs_q.size() - csb !== 1) begin
                miscompares++; $display("FAIL rnd_cs_count: got %0d want 1", cs_q.size() - csb);
            end else begin
                vectors++;
                if (cs_q[csb] !== h + 1) begin
                    miscompares++; $display("FAIL rnd_cs_cycle: got %0d want %0d", cs_q[csb], h + 1);
                end
            end
            vectors++;
            if ({s_adr, s_we, s_sel, s_dat} !== {4'h0, a[27:4], 4'h0, w, s, d}) begin
                miscompares++; $display("FAIL rnd_cfg_fields: got adr=%h we=%b sel=%h want adr=%h we=%b sel=%h",
                    s_adr, s_we, s_sel, {4'h0, a[27:4], 4'h0}, w, s);
            end
            vectors++;
            if (abort_n - abb !== int'(exp_ab)) begin
                miscompares++; $display("FAIL rnd_abort: got %0d want %0d", abort_n - abb, exp_ab);
            end
            if (exp_ab) begin
                vectors++;
                if (m_err !== 1'b1) begin
                    miscompares++; $display("FAIL rnd_err: got %b want 1", m_err);
                end
            end
            $display("txn m%0d #%0d %s adr=%h j=%0d hit@%0d", m1, t, w ? "wr" : "rd", a, j, h);
        end
        clr_err = 1'b1; tick(); clr_err = 1'b0; tick();
    endtask

    initial begin
        test_reset();
        test_mode0_read();
        test_mode0_write();
        test_mode1_timeout();
        test_err_priority();
        test_non_window();
        test_back_to_back();
        test_cpu_drop();
        test_reset_mid();
        test_random(1'b0, 12);
        test_random(1'b1, 16);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
